// File: rtl/rv_master_fifo.sv
// Buffered ready/valid master: producer writes bytes into a DEPTH-entry circular
// buffer whose head is presented to a downstream slave as data/master_valid.
module rv_master_fifo #(
  parameter int DEPTH     = 8,
  parameter int MAX_STALL = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               data,
  output logic                     master_valid,
  input  logic                     slave_ready,
  output logic [15:0]              xfer_count,
  output logic                     overflow,
  output logic                     stall_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  // Handshake: a transfer happens at a posedge where master_valid && slave_ready.
  // master_valid and data come only from flops, so they never depend on
  // slave_ready, and they hold until the transfer that consumes the head.

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [15:0]   xfer_count_q, xfer_count_d;
  logic          overflow_q, overflow_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          stall_err_q, stall_err_d;
  logic          do_wr, do_xfer;

  assign master_valid = (count_q != '0);
  assign data         = master_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count        = count_q;
  assign full         = full_q;
  assign xfer_count   = xfer_count_q;
  assign overflow     = overflow_q;
  assign stall_err    = stall_err_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    xfer_count_d = xfer_count_q;
    overflow_d   = overflow_q;
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q;

    // A write against a full buffer is dropped even if the head leaves this cycle.
    do_wr   = wr_en && !full_q;
    do_xfer = master_valid && slave_ready;

    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (wr_en && full_q) overflow_d = 1'b1;

    if (do_xfer) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      xfer_count_d = xfer_count_q + 16'd1;
    end

    count_d = count_q + CW'(do_wr) - CW'(do_xfer);
    full_d  = (count_d == CW'(DEPTH));

    if (do_xfer) begin
      stall_cnt_d = '0;
    end else if (master_valid && stall_cnt_q < STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end
    if (MAX_STALL != 0 && stall_cnt_d == STALL_MAX) stall_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      xfer_count_q <= '0;
      overflow_q   <= 1'b0;
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      xfer_count_q <= xfer_count_d;
      overflow_q   <= overflow_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

  // Storage needs no reset: data is gated to zero whenever nothing is held.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_rv_master_fifo.sv
// Bench for rv_master_fifo: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_rv_master_fifo;

  localparam int DEPTH     = 8;
  localparam int MAX_STALL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        slave_ready = 1'b0;
  logic        full;
  logic [3:0]  count;
  logic [7:0]  data;
  logic        master_valid;
  logic [15:0] xfer_count;
  logic        overflow;
  logic        stall_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [15:0] m_xfers;
  bit         m_overflow;
  int         m_stall;
  bit         m_stall_err;

  rv_master_fifo #(.DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .data(data), .master_valid(master_valid),
    .slave_ready(slave_ready), .xfer_count(xfer_count),
    .overflow(overflow), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input bit r, input bit w, input logic [7:0] wd, input bit rdy);
    bit had_valid;
    bit xfer;
    bit accept;
    if (r) begin
      exp_q.delete();
      m_xfers = 16'd0;
      m_overflow = 0;
      m_stall = 0;
      m_stall_err = 0;
      return;
    end
    had_valid = exp_q.size() > 0;
    xfer   = had_valid && rdy;
    accept = w && exp_q.size() < DEPTH;
    if (w && !accept) m_overflow = 1;
    if (xfer) begin
      void'(exp_q.pop_front());
      m_xfers = m_xfers + 16'd1;
      m_stall = 0;
    end else if (had_valid && m_stall < MAX_STALL) begin
      m_stall++;
    end
    if (MAX_STALL != 0 && m_stall == MAX_STALL) m_stall_err = 1;
    if (accept) exp_q.push_back(wd);
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("master_valid", 32'(master_valid), 32'(n > 0));
    check("data", 32'(data), (n > 0) ? 32'(exp_q[0]) : 32'h0);
    check("xfer_count", 32'(xfer_count), 32'(m_xfers));
    check("overflow", 32'(overflow), 32'(m_overflow));
    check("stall_err", 32'(stall_err), 32'(m_stall_err));
  endtask

  // One clock: drive inputs, take the edge, update the model, compare after the edge.
  task automatic cycle(input bit r, input bit w, input logic [7:0] wd, input bit rdy);
    rst = r; wr_en = w; wr_data = wd; slave_ready = rdy;
    @(posedge clk);
    model_step(r, w, wd, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h00, 0);
  endtask

  initial begin
    // Reset: two cycles with wr_en asserted, nothing taken
    cycle(1, 1, 8'h55, 1);
    cycle(1, 1, 8'h66, 1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_valid", 32'(master_valid), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    cycle(0, 0, 8'h00, 1);
    check("rst_no_write", 32'(master_valid), 32'h0);

    // Streaming 01..08 with ready held high
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 8'(i), 1);
      check("stream_data", 32'(data), 32'(i));
    end
    cycle(0, 0, 8'h00, 1);
    check("stream_xfers", 32'(xfer_count), 32'd8);
    check("stream_empty", 32'(master_valid), 32'h0);

    // Backpressure: hold A5 for 5 cycles
    do_reset();
    cycle(0, 1, 8'hA5, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 8'h00, 0);
      check("bp_data", 32'(data), 32'hA5);
      check("bp_valid", 32'(master_valid), 32'h1);
    end
    cycle(0, 0, 8'h00, 1);
    check("bp_xfers", 32'(xfer_count), 32'd1);
    check("bp_valid_drop", 32'(master_valid), 32'h0);

    // Full/overflow: 9 writes while stalled, then drain
    do_reset();
    for (int i = 1; i <= 9; i++) cycle(0, 1, 8'(8'h10 + i), 0);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'h1);
    check("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain_data", 32'(data), 32'(8'h10 + i));
      cycle(0, 0, 8'h00, 1);
    end
    check("ovf_drained", 32'(master_valid), 32'h0);
    check("ovf_xfers", 32'(xfer_count), 32'd8);

    // Stall limit: 15 stalled cycles is quiet, the 16th trips stall_err
    do_reset();
    cycle(0, 1, 8'h3C, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 8'h00, 0);
    check("stall_15", 32'(stall_err), 32'h0);
    cycle(0, 0, 8'h00, 0);
    check("stall_16", 32'(stall_err), 32'h1);
    cycle(0, 0, 8'h00, 1);
    check("stall_sticky", 32'(stall_err), 32'h1);

    // Reset mid-operation with 4 entries held
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'hC0 + i), 0);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'hEE, 0);
    check("mid_count_pre", 32'(count), 32'd4);
    cycle(1, 0, 8'h00, 0);
    check("mid_count", 32'(count), 32'h0);
    check("mid_valid", 32'(master_valid), 32'h0);
    check("mid_xfers", 32'(xfer_count), 32'h0);

    // Random traffic with varying write/ready densities and rare resets
    for (int phase = 0; phase < 4; phase++) begin
      int wr_pct;
      int rdy_pct;
      wr_pct  = 20 + 25 * phase;
      rdy_pct = 90 - 25 * phase;
      for (int i = 0; i < 600; i++) begin
        cycle($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < wr_pct,
              8'($urandom_range(0, 255)),
              $urandom_range(0, 99) < rdy_pct);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
